// File: rtl/bitwise_pkg.sv
// Shared definitions for the bitwise sequencer: op encoding, FSM states,
// and a helper sizing the chunk counter.
package bitwise_pkg;

  localparam logic [2:0] OP_AND    = 3'd0;
  localparam logic [2:0] OP_OR     = 3'd1;
  localparam logic [2:0] OP_XOR    = 3'd2;
  localparam logic [2:0] OP_NAND   = 3'd3;
  localparam logic [2:0] OP_NOR    = 3'd4;
  localparam logic [2:0] OP_XNOR   = 3'd5;
  localparam logic [2:0] OP_NOT_A  = 3'd6;
  localparam logic [2:0] OP_PASS_A = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width of a counter spanning 0..n-1, never narrower than one bit.
  function automatic int chunk_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bitwise_lane.sv
// Combinational LANE-bit logic slice; the only logic operator in the datapath.
module bitwise_lane
  import bitwise_pkg::*;
#(
  parameter int LANE = 4
) (
  input  logic [LANE-1:0] a,
  input  logic [LANE-1:0] b,
  input  logic [2:0]      op,
  output logic [LANE-1:0] y
);

  // Select one of the eight bitwise functions for this chunk.
  always_comb begin
    // NOTE: default assignment first so no path leaves y unassigned (no latch).
    y = '0;
    case (op)
      OP_AND:    y = a & b;
      OP_OR:     y = a | b;
      OP_XOR:    y = a ^ b;
      OP_NAND:   y = ~(a & b);
      OP_NOR:    y = ~(a | b);
      OP_XNOR:   y = ~(a ^ b);
      OP_NOT_A:  y = ~a;
      OP_PASS_A: y = a;
    endcase
  end

endmodule

// File: rtl/bitwise_seq.sv
// Handshaked bitwise logic unit: processes WIDTH-bit operands LANE bits per
// cycle through one shared slice, and reports zero/negative flags.
module bitwise_seq
  import bitwise_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LANE  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
);

  localparam int              NCHUNK = WIDTH / LANE;
  localparam int              CNT_W  = chunk_cnt_w(NCHUNK);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(NCHUNK - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [2:0]       r_op;
  logic [CNT_W-1:0] r_cnt;

  logic [LANE-1:0]  w_y;
  logic [WIDTH-1:0] w_res_next;
  logic             w_accept;

  bitwise_lane #(.LANE(LANE)) u_lane (
    .a  (r_a[LANE-1:0]),
    .b  (r_b[LANE-1:0]),
    .op (r_op),
    .y  (w_y)
  );

  // New chunk enters at the top; after NCHUNK shifts chunk 0 sits at the bottom.
  generate
    if (LANE == WIDTH) begin : g_single
      assign w_res_next = w_y;
    end else begin : g_multi
      assign w_res_next = {w_y, r_res[WIDTH-1:LANE]};
    end
  endgenerate

  // DONE may hand over to a new request in the same edge it releases the result.
  assign in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == ST_DONE);
  assign out       = r_res;
  assign zr        = ~|r_res;
  assign ng        = r_res[WIDTH-1];

  // Control FSM plus operand/result shift registers and chunk counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: operands are cleared too so every register starts from a known value.
      r_state <= ST_IDLE;
      r_res   <= '0;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= OP_AND;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= op;
            r_cnt   <= '0;
            r_state <= ST_BUSY;
          end else if (r_state == ST_DONE && out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          r_res <= w_res_next;
          r_a   <= r_a >> LANE;
          r_b   <= r_b >> LANE;
          if (r_cnt == LAST) begin
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitwise_seq.sv
// Self-checking bench for bitwise_seq: default, single-cycle and bit-serial
// instances against a whole-word behavioural model.
module tb_bitwise_seq;
  import bitwise_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Default instance (16/4)
  logic        d0_in_valid = 1'b0, d0_out_ready = 1'b1;
  logic        d0_in_ready, d0_out_valid, d0_zr, d0_ng;
  logic [15:0] d0_a = '0, d0_b = '0, d0_out;
  logic [2:0]  d0_op = '0;

  // Single-cycle instance (16/16)
  logic        d1_in_valid = 1'b0, d1_out_ready = 1'b1;
  logic        d1_in_ready, d1_out_valid, d1_zr, d1_ng;
  logic [15:0] d1_a = '0, d1_b = '0, d1_out;
  logic [2:0]  d1_op = '0;

  // Bit-serial instance (8/1)
  logic        d2_in_valid = 1'b0, d2_out_ready = 1'b1;
  logic        d2_in_ready, d2_out_valid, d2_zr, d2_ng;
  logic [7:0]  d2_a = '0, d2_b = '0, d2_out;
  logic [2:0]  d2_op = '0;

  bitwise_seq #(.WIDTH(16), .LANE(4)) u_d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(d0_in_valid), .in_ready(d0_in_ready),
    .a(d0_a), .b(d0_b), .op(d0_op), .out_valid(d0_out_valid),
    .out_ready(d0_out_ready), .out(d0_out), .zr(d0_zr), .ng(d0_ng));

  bitwise_seq #(.WIDTH(16), .LANE(16)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
    .a(d1_a), .b(d1_b), .op(d1_op), .out_valid(d1_out_valid),
    .out_ready(d1_out_ready), .out(d1_out), .zr(d1_zr), .ng(d1_ng));

  bitwise_seq #(.WIDTH(8), .LANE(1)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(d2_in_valid), .in_ready(d2_in_ready),
    .a(d2_a), .b(d2_b), .op(d2_op), .out_valid(d2_out_valid),
    .out_ready(d2_out_ready), .out(d2_out), .zr(d2_zr), .ng(d2_ng));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Whole-word reference, masked to the instance width.
  function automatic logic [15:0] model(input logic [2:0] o, input logic [15:0] x,
                                        input logic [15:0] y, input int w);
    logic [15:0] r;
    logic [15:0] m;
    case (o)
      OP_AND:   r = x & y;
      OP_OR:    r = x | y;
      OP_XOR:   r = x ^ y;
      OP_NAND:  r = ~(x & y);
      OP_NOR:   r = ~(x | y);
      OP_XNOR:  r = ~(x ^ y);
      OP_NOT_A: r = ~x;
      default:  r = x;
    endcase
    m = (w >= 16) ? 16'hFFFF : 16'((32'h1 << w) - 1);
    return r & m;
  endfunction

  // One request on the default instance; optional stall cycles in DONE.
  task automatic txn0(input logic [15:0] ta, input logic [15:0] tb_v, input logic [2:0] top,
                      input int stall, input logic [15:0] exp, input string tag);
    int lat;
    logic [15:0] held;
    d0_a = ta; d0_b = tb_v; d0_op = top; d0_in_valid = 1'b1;
    #1;
    check({tag, "_acc_rdy"}, 32'(d0_in_ready), 32'd1);
    @(posedge clk); #1;
    d0_in_valid  = 1'b0;
    d0_out_ready = (stall == 0);
    lat = 0;
    while (!d0_out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'd4);
    check({tag, "_out"}, 32'(d0_out), 32'(exp));
    check({tag, "_zr"},  32'(d0_zr), 32'(exp == 16'h0));
    check({tag, "_ng"},  32'(d0_ng), 32'(exp[15]));
    held = d0_out;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_ov"},  32'(d0_out_valid), 32'd1);
      check({tag, "_hold_out"}, 32'(d0_out), 32'(held));
      check({tag, "_hold_rdy"}, 32'(d0_in_ready), 32'd0);
    end
    d0_out_ready = 1'b1;
  endtask

  task automatic txn1(input logic [15:0] ta, input logic [15:0] tb_v, input logic [2:0] top,
                      input logic [15:0] exp, input string tag);
    int lat;
    d1_a = ta; d1_b = tb_v; d1_op = top; d1_in_valid = 1'b1;
    #1;
    check({tag, "_acc_rdy"}, 32'(d1_in_ready), 32'd1);
    @(posedge clk); #1;
    d1_in_valid = 1'b0;
    lat = 0;
    while (!d1_out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'd1);
    check({tag, "_out"}, 32'(d1_out), 32'(exp));
  endtask

  task automatic txn2(input logic [7:0] ta, input logic [7:0] tb_v, input logic [2:0] top,
                      input logic [7:0] exp, input string tag);
    int lat;
    d2_a = ta; d2_b = tb_v; d2_op = top; d2_in_valid = 1'b1;
    #1;
    check({tag, "_acc_rdy"}, 32'(d2_in_ready), 32'd1);
    @(posedge clk); #1;
    d2_in_valid = 1'b0;
    lat = 0;
    while (!d2_out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'd8);
    check({tag, "_out"}, 32'(d2_out), 32'(exp));
    check({tag, "_ng"},  32'(d2_ng), 32'(exp[7]));
  endtask

  logic [15:0] sweep_exp [8] = '{16'hF000, 16'hFFF0, 16'h0FF0, 16'h0FFF,
                                 16'h000F, 16'hF00F, 16'h0F0F, 16'hF0F0};

  initial begin
    logic [15:0] ra, rb;
    logic [2:0]  ro;
    logic        saw;

    // Reset and idle
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_in_ready",  32'(d0_in_ready),  32'd1);
    check("rst_out_valid", 32'(d0_out_valid), 32'd0);
    check("rst_out",       32'(d0_out),       32'd0);
    check("rst_zr",        32'(d0_zr),        32'd1);
    check("rst_ng",        32'(d0_ng),        32'd0);

    // Op sweep against fixed expected results, back-to-back
    for (int i = 0; i < 8; i++)
      txn0(16'hF0F0, 16'hFF00, 3'(i), 0, sweep_exp[i], $sformatf("sweep%0d", i));

    // Flags
    txn0(16'h8000, 16'h8000, OP_AND, 0, 16'h8000, "flag_ng");
    txn0(16'h00FF, 16'hFF00, OP_AND, 0, 16'h0000, "flag_zr");

    // Backpressure then back-to-back accept
    txn0(16'h1234, 16'h5678, OP_XOR, 5, 16'h444C, "bp");
    txn0(16'hA5A5, 16'h0FF0, OP_OR,  0, 16'hAFF5, "b2b");

    // Randomized against model
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); ro = 3'($urandom_range(0, 7));
      txn0(ra, rb, ro, int'($urandom_range(0, 2)), model(ro, ra, rb, 16), $sformatf("rnd%0d", i));
    end

    // Reset mid-BUSY discards the request
    d0_a = 16'hFFFF; d0_b = 16'hFFFF; d0_op = OP_AND; d0_in_valid = 1'b1;
    @(posedge clk); #1;
    d0_in_valid = 1'b0;
    saw = 1'b0;
    repeat (2) begin @(posedge clk); #1; saw |= d0_out_valid; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    saw |= d0_out_valid;
    rst_n = 1'b1;
    repeat (8) begin @(posedge clk); #1; saw |= d0_out_valid; end
    check("rstbusy_no_valid", 32'(saw), 32'd0);
    check("rstbusy_out",      32'(d0_out), 32'd0);
    check("rstbusy_rdy",      32'(d0_in_ready), 32'd1);
    check("rstbusy_zr",       32'(d0_zr), 32'd1);

    // Single-cycle instance
    txn1(16'hF0F0, 16'hFF00, OP_XNOR, 16'hF00F, "l16_fix");
    for (int i = 0; i < 6; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); ro = 3'($urandom_range(0, 7));
      txn1(ra, rb, ro, model(ro, ra, rb, 16), $sformatf("l16_rnd%0d", i));
    end

    // Bit-serial instance
    txn2(8'hA5, 8'h3C, OP_XOR, 8'h99, "w8_fix");
    for (int i = 0; i < 6; i++) begin
      ra = 16'($urandom_range(0, 255)); rb = 16'($urandom_range(0, 255));
      ro = 3'($urandom_range(0, 7));
      txn2(ra[7:0], rb[7:0], ro, model(ro, ra, rb, 8)[7:0], $sformatf("w8_rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bitwise_seq.md
# bitwise_seq

Parametrised, handshaked bitwise logic unit. It generalises the fixed 16-bit AND to any `WIDTH` and eight selectable operations. Operands are processed `LANE` bits per cycle through a single lane-wide logic slice, so area trades against latency. The block sits between operand registers and the ALU result mux. It also produces the `zr`/`ng` status flags the ALU already reports.

## Interface
- `WIDTH`, 16: operand and result width. Must be ≥ 1.
- `LANE`, 4: bits processed per cycle. Must satisfy `WIDTH % LANE == 0`. `LANE == WIDTH` gives single-cycle operation.
- `clk` input 1: the single clock. All state updates on its rising edge.
- `rst_n` input 1: reset. Synchronous and active-low.
- `in_valid` input 1: operands and op are valid.
- `in_ready` output 1: the block can accept a request.
- `a` input WIDTH: operand A.
- `b` input WIDTH: operand B. Ignored for NOT_A and PASS_A.
- `op` input 3: operation select.
- `out_valid` output 1: the result is valid.
- `out_ready` input 1: the consumer accepts the result.
- `out` output WIDTH: the result.
- `zr` output 1: `out == 0`. Only meaningful while `out_valid` is high.
- `ng` output 1: `out[WIDTH-1]`. Only meaningful while `out_valid` is high.

## Operation
- `op` encoding:
  - 0 AND
  - 1 OR
  - 2 XOR
  - 3 NAND
  - 4 NOR
  - 5 XNOR
  - 6 NOT_A
  - 7 PASS_A
- FSM states: IDLE, BUSY, DONE.
- **IDLE:** `in_ready=1`. On `in_valid`:
  - latch `a`, `b` and `op`;
  - clear the chunk counter;
  - go to BUSY.
- **BUSY:** `in_ready=0`.
  - Each cycle, the slice processes the low `LANE` bits of the operand shift registers.
  - The result is shifted into the top of the result register, and both operand shift registers shift right by `LANE`.
  - Result chunk i corresponds to bits `[i*LANE +: LANE]`, lowest chunk first.
  - After chunk `WIDTH/LANE-1` is processed, go to DONE.
- **DONE:** `out_valid=1`. `out`, `zr` and `ng` are held stable until `out_ready`.
  - `out_ready=1`, `in_valid=0`: go to IDLE.
  - `out_ready=1`, `in_valid=1`: `in_ready` is high in this case. The new request is latched and the block goes directly to BUSY (back-to-back accept, no bubble).
  - `out_ready=0`: `in_ready=0`; the block stays in DONE.
- `op` values are all defined, so no illegal-op handling is needed.
- Synchronous reset while `rst_n=0`, checked at each edge:
  - state → IDLE;
  - `out_valid=0`, result register 0, chunk counter 0.
  - After the reset edge: `in_ready=1`, `out=0`, `zr=1`, `ng=0`.
- Reset mid-BUSY or mid-DONE discards the in-flight request. No partial result is ever presented.
- The chunk counter is `$clog2(WIDTH/LANE)` bits wide, with a minimum of 1 bit. It counts 0 … `WIDTH/LANE-1` and does not wrap further.

## Timing
- An accept occurs on edge k, when `in_valid && in_ready`.
- `out_valid` rises after edge k + `WIDTH/LANE`. With the defaults, the latency is 4 cycles.
- `LANE == WIDTH`: BUSY lasts one cycle, so `out_valid` rises after edge k+1.
- Throughput under back-to-back requests with `out_ready` held high: one result per `WIDTH/LANE + 1` cycles.
- `in_ready`, `out_valid`, `out`, `zr` and `ng` are driven from registers or from state decode only.
  - Exception: `in_ready` in DONE is combinational on `out_ready`.
  - No input-to-output combinational path exists other than `out_ready → in_ready`.
- `zr` and `ng` are derived from the result register, with no extra cycle of latency.

## Structure
- A shared package `bitwise_pkg` holds:
  - the `op` encoding constants (`OP_AND` … `OP_PASS_A`);
  - the FSM state typedef.
- Sub-module `bitwise_lane`: combinational, parameter `LANE`, ports `a`, `b`, `op`, `y`. It is instantiated once.
- The top level holds the FSM, the operand shift registers, the result register and the counter.

## Test plan
All scenarios use the default parameters unless stated.

1. **Reset and idle.** Drive `rst_n=0` for 2 cycles, then release. Required: `in_ready=1`, `out_valid=0`, `out=0`, `zr=1`, `ng=0`.
2. **Full op sweep.** Use `a=16'hF0F0`, `b=16'hFF00`, `op=0..7`, with `out_ready=1`. Required results, each arriving 4 cycles after accept:
   - AND `F000`
   - OR `FFF0`
   - XOR `0FF0`
   - NAND `0FFF`
   - NOR `000F`
   - XNOR `F00F`
   - NOT_A `0F0F`
   - PASS_A `F0F0`
3. **Flags.** `a=16'h8000`, `b=16'h8000`, AND gives `out=8000`, `ng=1`, `zr=0`. `a=16'h00FF`, `b=16'hFF00`, AND gives `out=0000`, `zr=1`, `ng=0`.
4. **Backpressure and back-to-back.** Hold `out_ready=0` for 5 cycles after `out_valid` rises. Required: `out` is stable and `in_ready=0` throughout. Then raise `out_ready` together with `in_valid` for a second request. Required: it is accepted on the same edge, and its `out_valid` follows 4 cycles later.
5. **Reset mid-BUSY.** Assert `rst_n=0` two cycles after an accept. Required: `out_valid` never asserts for that request; the block returns to IDLE with `out=0`.
6. **Parameter corners.**
   - `WIDTH=16`, `LANE=16`: latency 1.
   - `WIDTH=8`, `LANE=1`, `a=8'hA5`, `b=8'h3C`, XOR: result `99` after 8 cycles.
